const_load_sequencer: RTL and testbench
=======================================

CONST_LOAD_SEQUENCER -- requirements
Module: const_load_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: CLK (rising edge) and Reset (synchronous, active-high).
REQ-002 The block SHALL have these ports:
- CLK  in  1  clock.
- Reset  in  1  synchronous active-high reset.
- ReqValid  in  1  load request.
- ReqReady  out  1  request accepted when ReqValid and ReqReady are both high.
- ReqRd  in  5  destination register.
- ReqValue  in  64  constant to materialise.
- Stall  in  1  hold current step; no write this cycle.
- Flush  in  1  abort current sequence.
- ExtInstr  out  26  drives the immediate generator's Instruction input.
- ExtIsMovZ  out  1  drives the immediate generator's IsMovZ input.
- ExtIn  in  64  immediate generator result, combinational in the same cycle.
- RegWrite  out  1  register-file write enable.
- RegWrAddr  out  5  write address.
- RegWrData  out  64  write data.
- Busy  out  1  sequence in progress.
- Done  out  1  one-cycle completion pulse.

Function
REQ-003 The block SHALL materialise ReqValue into ReqRd as one MOVZ step followed by zero to three MOVK steps, one 16-bit halfword (hw = 0..3) per step.
REQ-004 The block SHALL skip zero halfwords: MOVZ targets the lowest nonzero halfword, and MOVK targets each higher nonzero halfword in ascending hw order.
REQ-005 If ReqValue is 0, the block SHALL issue exactly one MOVZ step with hw = 0 and imm16 = 0.
REQ-006 The step count SHALL be max(1, number of nonzero halfwords), in the range 1..4.
REQ-007 The block SHALL have these states:
- IDLE -> MOVZ on an accepted request.
- MOVZ -> MOVK if a higher nonzero halfword remains, otherwise -> IDLE.
- MOVK -> MOVK while a higher nonzero halfword remains, otherwise -> IDLE.
REQ-008 ReqReady SHALL equal (state == IDLE); Busy SHALL equal its inverse.
REQ-009 On acceptance, the block SHALL latch ReqValue and ReqRd and clear the accumulator to 0.
REQ-010 The first step SHALL occur in the cycle after acceptance.
REQ-011 In each step cycle, ExtInstr SHALL be {3'b101, hw[1:0], imm16, Rd}, where imm16 = latched value[16*hw+15 : 16*hw].
REQ-012 ExtIsMovZ SHALL be 1 in every step cycle, so the generator returns imm16 << 16*hw; ExtInstr and ExtIsMovZ SHALL be 0 in IDLE.
REQ-013 RegWrData SHALL be ExtIn in a MOVZ step and (accumulator | ExtIn) in a MOVK step.
REQ-014 In a step cycle where Stall is low, the block SHALL:
- assert RegWrite;
- drive RegWrAddr = Rd;
- register the accumulator <= RegWrData;
- advance the state.
REQ-015 While Stall is high, the block SHALL hold state, hw and accumulator, drive RegWrite = 0, and keep ExtInstr stable.
REQ-016 Done SHALL pulse high for one cycle, coincident with the write of the final step.
REQ-017 Latency from acceptance to Done SHALL be N cycles (N = step count) plus the number of stalled cycles.
REQ-018 If Rd = 31 (XZR), the block SHALL keep the sequence and timing unchanged but hold RegWrite at 0 throughout; Done SHALL still pulse.
REQ-019 Flush high in any non-IDLE state SHALL return the block to IDLE at the next edge with no write in that cycle and no Done pulse; Flush SHALL take priority over Stall.
REQ-020 Flush high in IDLE SHALL have no effect on acceptance; a request presented while Flush is high SHALL still be accepted.
REQ-021 The block SHALL accept back-to-back requests: a new request is accepted in the first cycle after Done.
REQ-022 The final RegWrData SHALL equal ReqValue bit-exactly.

Reset
REQ-023 When Reset is high at a clock edge, the block SHALL go to IDLE and clear hw, Rd, the latched value and the accumulator to 0, including when the reset arrives mid-sequence.
REQ-024 During and after reset, the block SHALL drive RegWrite = 0, Done = 0, Busy = 0, ReqReady = 1, ExtInstr = 0, ExtIsMovZ = 0 and RegWrData = 0.
REQ-025 A write that would have occurred in a reset cycle SHALL be suppressed.

Structure
REQ-026 A shared package const_seq_pkg SHALL hold the state encoding (IDLE, MOVZ, MOVK), the MOV opcode-slice constant 3'b101 and the XZR index 31.
REQ-027 A single sub-module, hw_scan, SHALL be used: combinational; it takes the latched value and the current hw and returns the next nonzero halfword index above hw, plus a valid flag.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- ReqValue = 0x0000_0000_0000_1234, Rd = 3 -> one MOVZ step with hw = 0; RegWrData = 0x1234; Done in cycle 1.
- ReqValue = 0xDEAD_BEEF_CAFE_F00D, Rd = 5 -> four steps with hw 0,1,2,3; final RegWrData = 0xDEADBEEFCAFEF00D; Done in cycle 4.
- ReqValue = 0x0001_0000_0000_0000 -> a single MOVZ step with hw = 3; ReqValue = 0 -> MOVZ with hw = 0 and imm16 = 0; RegWrData = 0.
- ReqValue = 0xFFFF_0000_0000_FFFF, Stall high for 2 cycles during step 2 -> RegWrite low while stalled; Done in cycle 4.
- Flush after step 1 of a 4-step load -> no further writes and no Done; the next request is accepted immediately; Rd = 31 -> no RegWrite, Done still pulses.
- Reset asserted mid-sequence -> outputs at their reset values on the next cycle; a new request completes correctly.

Source files
------------

// File: rtl/const_load_sequencer_pkg.sv
// Shared definitions for the constant-load sequencer.
//   seqState_t : FSM encoding (IDLE, MOVZ, MOVK)
//   movOpc     : opcode slice placed in ExtInstr[25:23]
//   xzrIdx     : zero-register index; writes to it are suppressed
//   firstHw()  : index of the lowest nonzero halfword (0 when the value is 0)
package const_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVZ = 2'd1,
    MOVK = 2'd2
  } seqState_t;

  localparam logic [2:0] movOpc = 3'b101;
  localparam logic [4:0] xzrIdx = 5'd31;

  function automatic logic [1:0] firstHw(input logic [63:0] value);
    logic [1:0] res;
    res = 2'd0;
    // Descending scan so the lowest nonzero halfword is the one that sticks.
    for (int i = 3; i >= 0; i--) begin
      if (value[16*i +: 16] != 16'd0) res = 2'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/const_load_sequencer_if.sv
// Bus bundle between the sequencer and its environment.
//   Request side  : ReqValid/ReqReady handshake, ReqRd, ReqValue
//   Control       : Stall, Flush
//   Imm generator : ExtInstr, ExtIsMovZ out; ExtIn back (same cycle)
//   Register file : RegWrite, RegWrAddr, RegWrData
//   Status        : Busy, Done
// The sequencer uses the slave modport; the environment uses master.
interface const_load_sequencer_if;
  logic        ReqValid;
  logic        ReqReady;
  logic [4:0]  ReqRd;
  logic [63:0] ReqValue;
  logic        Stall;
  logic        Flush;
  logic [25:0] ExtInstr;
  logic        ExtIsMovZ;
  logic [63:0] ExtIn;
  logic        RegWrite;
  logic [4:0]  RegWrAddr;
  logic [63:0] RegWrData;
  logic        Busy;
  logic        Done;

  modport master (
    output ReqValid, ReqRd, ReqValue, Stall, Flush, ExtIn,
    input  ReqReady, ExtInstr, ExtIsMovZ, RegWrite, RegWrAddr, RegWrData,
           Busy, Done
  );

  modport slave (
    input  ReqValid, ReqRd, ReqValue, Stall, Flush, ExtIn,
    output ReqReady, ExtInstr, ExtIsMovZ, RegWrite, RegWrAddr, RegWrData,
           Busy, Done
  );
endinterface

// File: rtl/const_load_sequencer_hw_scan.sv
// hw_scan: combinational search for the next nonzero halfword strictly above
// the current one.
//   value     : latched 64-bit constant
//   hw        : current halfword index
//   nextHw    : lowest nonzero halfword index above hw (hw when none)
//   nextValid : 1 when such a halfword exists
module hw_scan (
  input  logic [63:0] value,
  input  logic [1:0]  hw,
  output logic [1:0]  nextHw,
  output logic        nextValid
);

  always_comb begin
    nextHw    = hw;
    nextValid = 1'b0;
    for (int i = 3; i >= 1; i--) begin
      if (2'(i) > hw && value[16*i +: 16] != 16'd0) begin
        nextHw    = 2'(i);
        nextValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/const_load_sequencer.sv
// const_load_sequencer: materialises a 64-bit constant into a register as one
// MOVZ followed by up to three MOVK steps, skipping zero halfwords.
//   CLK   : rising-edge clock
//   Reset : synchronous active-high reset
//   bus   : request handshake, stall/flush, immediate-generator link,
//           register-file write port and Busy/Done status
module const_load_sequencer
  import const_seq_pkg::*;
(
  input  logic                   CLK,
  input  logic                   Reset,
  const_load_sequencer_if.slave  bus
);

  seqState_t   state;
  seqState_t   nextState;
  logic [1:0]  hw;
  logic [4:0]  rd;
  logic [63:0] value;
  logic [63:0] acc;
  logic [1:0]  nextHw;
  logic        nextValid;
  logic        active;
  logic        advance;
  logic        accept;

  hw_scan uScan (
    .value     (value),
    .hw        (hw),
    .nextHw    (nextHw),
    .nextValid (nextValid)
  );

  // Reset forces every output to its idle value in the reset cycle itself,
  // which also suppresses a write that would otherwise land there.
  assign active  = (state != IDLE) && !Reset;
  assign advance = active && !bus.Stall && !bus.Flush;
  assign accept  = (state == IDLE) && bus.ReqValid;

  assign bus.ReqReady  = (state == IDLE) || Reset;
  assign bus.Busy      = active;
  assign bus.ExtIsMovZ = active;
  assign bus.ExtInstr  = active ? {movOpc, hw, value[{hw, 4'b0000} +: 16], rd} : 26'd0;
  assign bus.RegWrData = !active          ? 64'd0 :
                         (state == MOVZ)  ? bus.ExtIn :
                                            (acc | bus.ExtIn);
  assign bus.RegWrAddr = active ? rd : 5'd0;
  assign bus.RegWrite  = advance && (rd != xzrIdx);
  assign bus.Done      = advance && !nextValid;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.ReqValid) nextState = MOVZ;
      end
      MOVZ, MOVK: begin
        // Flush outranks Stall.
        if (bus.Flush)       nextState = IDLE;
        else if (!bus.Stall) nextState = nextValid ? MOVK : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      hw    <= 2'd0;
      rd    <= 5'd0;
      value <= 64'd0;
      acc   <= 64'd0;
    end else if (accept) begin
      value <= bus.ReqValue;
      rd    <= bus.ReqRd;
      hw    <= firstHw(bus.ReqValue);
      acc   <= 64'd0;
    end else if (advance) begin
      acc <= bus.RegWrData;
      if (nextValid) hw <= nextHw;
    end
  end

endmodule

// File: tb/tb_const_load_sequencer.sv
// Bench for const_load_sequencer: directed loads plus randomized loads with
// random stalls, flushes and mid-sequence resets, checked cycle by cycle
// against a halfword-list reference model.
module tb_const_load_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic [63:0] idleNoise;

  always #5 clk = ~clk;

  const_load_sequencer_if bus ();

  const_load_sequencer dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Immediate generator: imm16 << 16*hw when IsMovZ, unrelated noise otherwise.
  assign bus.ExtIn = bus.ExtIsMovZ ?
                     (64'(bus.ExtInstr[20:5]) << {bus.ExtInstr[22:21], 4'b0000}) :
                     idleNoise;

  int errors = 0;
  int checks = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, "_ready"},  64'(bus.ReqReady),  64'd1);
    checkVal({tag, "_busy"},   64'(bus.Busy),      64'd0);
    checkVal({tag, "_write"},  64'(bus.RegWrite),  64'd0);
    checkVal({tag, "_done"},   64'(bus.Done),      64'd0);
    checkVal({tag, "_instr"},  64'(bus.ExtInstr),  64'd0);
    checkVal({tag, "_movz"},   64'(bus.ExtIsMovZ), 64'd0);
    checkVal({tag, "_wrdata"}, bus.RegWrData,      64'd0);
  endtask

  // Called and returns just after a falling edge.
  task automatic doLoad(input logic [63:0] v, input logic [4:0] rd,
                        input int stallPct, input int stallStep, input int stallLen,
                        input int flushStep, input int resetStep);
    int          hws[$];
    int          k, stalls, cyc, doneAt, stallCnt, hwv;
    logic [15:0] imm;
    logic [63:0] acc, expData, lastData;
    logic        stall, flush, wr, dn;
    bit          aborted;

    for (int i = 0; i < 4; i++) if (v[16*i +: 16] != 16'd0) hws.push_back(i);
    if (hws.size() == 0) hws.push_back(0);

    bus.ReqValid = 1'b1;
    bus.ReqValue = v;
    bus.ReqRd    = rd;
    bus.Stall    = 1'($urandom_range(1));
    bus.Flush    = 1'($urandom_range(1));
    idleNoise    = {$urandom, $urandom};
    rst          = 1'b0;
    #1;
    checkVal("accept_ready", 64'(bus.ReqReady), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.ReqValid = 1'b0;
    bus.ReqValue = {$urandom, $urandom};
    bus.ReqRd    = 5'($urandom);

    k = 0; acc = 64'd0; stalls = 0; cyc = 0; doneAt = -1; stallCnt = 0;
    aborted = 1'b0; lastData = 64'd0;
    while (k < hws.size() && !aborted) begin
      cyc++;
      hwv   = hws[k];
      imm   = v[16*hwv +: 16];
      stall = 1'b0;
      if (k == stallStep && stallCnt < stallLen) begin
        stall = 1'b1;
        stallCnt++;
      end else if ($urandom_range(99) < stallPct && stalls < 8) begin
        stall = 1'b1;
      end
      flush     = (k == flushStep);
      bus.Stall = stall;
      bus.Flush = flush;
      rst       = (k == resetStep);
      idleNoise = {$urandom, $urandom};
      #1;
      if (k == resetStep) begin
        checkIdle("reset_mid");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; bus.Stall = 1'b0; bus.Flush = 1'b0;
        #1;
        checkIdle("after_reset");
        aborted = 1'b1;
      end else begin
        expData = acc | (64'(imm) << (16 * hwv));
        wr = !stall && !flush && (rd != 5'd31);
        dn = !stall && !flush && (k == hws.size() - 1);
        checkVal("ext_instr", 64'(bus.ExtInstr), 64'({3'b101, 2'(hwv), imm, rd}));
        checkVal("ext_movz",  64'(bus.ExtIsMovZ), 64'd1);
        checkVal("busy",      64'(bus.Busy), 64'd1);
        checkVal("ready",     64'(bus.ReqReady), 64'd0);
        checkVal("wr_data",   bus.RegWrData, expData);
        checkVal("reg_write", 64'(bus.RegWrite), 64'(wr));
        if (wr) checkVal("wr_addr", 64'(bus.RegWrAddr), 64'(rd));
        checkVal("done",      64'(bus.Done), 64'(dn));
        if (bus.Done) begin
          doneAt   = cyc;
          lastData = bus.RegWrData;
        end
        @(posedge clk);
        @(negedge clk);
        if (flush)      aborted = 1'b1;
        else if (stall) stalls++;
        else begin
          acc = expData;
          k++;
        end
      end
    end
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    rst       = 1'b0;
    if (!aborted) begin
      checkVal("latency",     64'(doneAt), 64'(hws.size() + stalls));
      checkVal("final_value", lastData, v);
    end else if (flushStep >= 0 && resetStep < 0) begin
      #1;
      checkIdle("after_flush");
    end
  endtask

  initial begin
    logic [63:0] rv;
    int          fs, rs;

    rst = 1'b1;
    bus.ReqValid = 1'b0; bus.ReqRd = 5'd0; bus.ReqValue = 64'd0;
    bus.Stall = 1'b0; bus.Flush = 1'b0;
    idleNoise = 64'hA5A5_5A5A_0F0F_F0F0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdle("in_reset");
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkIdle("post_reset");

    doLoad(64'h0000_0000_0000_1234, 5'd3,  0, -1, 0, -1, -1);
    doLoad(64'hDEAD_BEEF_CAFE_F00D, 5'd5,  0, -1, 0, -1, -1);
    doLoad(64'h0001_0000_0000_0000, 5'd7,  0, -1, 0, -1, -1);
    doLoad(64'h0000_0000_0000_0000, 5'd9,  0, -1, 0, -1, -1);
    doLoad(64'hFFFF_0000_0000_FFFF, 5'd2,  0,  1, 2, -1, -1);
    doLoad(64'hDEAD_BEEF_CAFE_F00D, 5'd4,  0, -1, 0,  1, -1);
    doLoad(64'h0123_0000_4567_89AB, 5'd31, 0, -1, 0, -1, -1);
    doLoad(64'h1111_2222_3333_4444, 5'd6,  0, -1, 0, -1,  2);
    doLoad(64'h1234_5678_9ABC_DEF0, 5'd8,  0, -1, 0, -1, -1);

    for (int n = 0; n < 150; n++) begin
      rv = {$urandom, $urandom};
      for (int h = 0; h < 4; h++) if ($urandom_range(1) == 0) rv[16*h +: 16] = 16'd0;
      fs = ($urandom_range(7) == 0) ? int'($urandom_range(3)) : -1;
      rs = ($urandom_range(15) == 0) ? int'($urandom_range(3)) : -1;
      doLoad(rv, 5'($urandom), 25, -1, 0, fs, rs);
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        @(negedge clk);
        #1;
        checkIdle("gap");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
